// File: rtl/multi_mode_mult_serial.sv
// rtl/multi_mode_mult_serial.sv - row-serial multi-mode redundant multiplier
// Optional carry-ripple normalisation stage enabled by MULT_SERIAL_NORM_EN.
module multi_mode_mult_serial #(
   parameter int NUM_ELEMENTS = 8,
   parameter int DSP_BIT_LEN  = 17,
   parameter int WORD_LEN     = 16,
   parameter int LANES        = 1
) (
   input  logic                                         i_clk,
   input  logic                                         i_rst_n,
   input  logic                                         i_val,
   output logic                                         o_rdy,
   input  logic [1:0]                                   i_mode,
   input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]     i_dat_a,
   input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]     i_dat_b,
   input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]     i_add_term,
   output logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   o_dat,
   output logic                                         o_val,
   input  logic                                         i_rdy
);
   localparam int N     = NUM_ELEMENTS;
   localparam int C     = 2 * NUM_ELEMENTS;
   localparam int D     = DSP_BIT_LEN;
   localparam int W     = WORD_LEN;
   localparam int P_W   = 2 * DSP_BIT_LEN;
   localparam int ACC_W = P_W - W + $clog2(C + 2);
   localparam int CW    = $clog2(C);
   localparam int RW    = $clog2(N + 1);

   typedef logic [C-1:0][D-1:0] dat_t;
   typedef enum logic [2:0] {S_IDLE, S_MAC, S_CARRY, S_NORM, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [RW-1:0]       r_row;
   logic [1:0]          r_mode;
   logic [N-1:0][D-1:0] r_a;
   logic [N-1:0][D-1:0] r_b;
   logic [ACC_W-1:0]    r_acc [C];
   logic [ACC_W-1:0]    w_col_add [C];
   logic [P_W-1:0]      w_prod [LANES][N];
   dat_t                w_res;
   dat_t                r_dat;
   logic                w_accept;
   logic                w_mac_last;

   function automatic dat_t map_out(input dat_t res, input logic [1:0] mode);
      dat_t v_out;
      v_out = '0;
      for (int i = 0; i < N; i++) begin
         case (mode)
            2'd0:    v_out[i] = res[i];
            2'd1:    v_out[i] = res[N+i];
            default: begin
               v_out[i]   = res[i];
               v_out[N+i] = res[N+i];
            end
         endcase
      end
      return v_out;
   endfunction

   assign w_accept   = (r_state == S_IDLE) && i_val;
   assign w_mac_last = (r_row == RW'(N - LANES));
   assign o_rdy      = (r_state == S_IDLE);
   assign o_val      = (r_state == S_DONE);
   assign o_dat      = r_dat;

`ifdef MULT_SERIAL_NORM_EN
   localparam int S_W = D + 1;
   logic [CW-1:0] r_nidx;
   logic [D-W:0]  r_ncarry;
   dat_t          r_nres;
   dat_t          w_nres_nxt;
   logic [S_W-1:0] w_nsum;

   // Top limb keeps its overflow; every other limb is reduced to WORD_LEN bits.
   always_comb begin
      w_nres_nxt = r_nres;
      w_nsum     = S_W'(r_nres[r_nidx]) + S_W'(r_ncarry);
      if (r_nidx == CW'(C - 1))
         w_nres_nxt[r_nidx] = w_nsum[D-1:0];
      else
         w_nres_nxt[r_nidx] = D'(w_nsum[W-1:0]);
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_val) w_state_nxt = S_MAC;
         S_MAC:   if (w_mac_last) w_state_nxt = S_CARRY;
`ifdef MULT_SERIAL_NORM_EN
         S_CARRY: w_state_nxt = S_NORM;
         S_NORM:  if (r_nidx == CW'(C - 1)) w_state_nxt = S_DONE;
`else
         S_CARRY: w_state_nxt = S_DONE;
`endif
         S_DONE:  if (i_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Row j = r_row + l of partial products, scattered into absolute columns.
   always_comb begin
      for (int c = 0; c < C; c++) w_col_add[c] = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int k = 0; k < N; k++) begin
            w_prod[l][k] = P_W'(r_a[k]) * P_W'(r_b[l]);
            w_col_add[CW'(int'(r_row) + l + k)] =
               w_col_add[CW'(int'(r_row) + l + k)] + ACC_W'(w_prod[l][k][W-1:0]);
            w_col_add[CW'(int'(r_row) + l + k + 1)] =
               w_col_add[CW'(int'(r_row) + l + k + 1)] + ACC_W'(w_prod[l][k][P_W-1:W]);
         end
      end
   end

   always_comb begin
      w_res[0] = D'(r_acc[0][W-1:0]);
      for (int c = 1; c < C; c++)
         w_res[c] = D'(r_acc[c][W-1:0]) + D'(r_acc[c-1][ACC_W-1:W]);
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_mode <= i_mode;
         r_a    <= i_dat_a;
         r_b    <= (i_mode == 2'd2) ? i_dat_a : i_dat_b;
         for (int c = 0; c < C; c++) r_acc[c] <= '0;
         for (int i = 0; i < N; i++) begin
            if (i_mode == 2'd1)
               r_acc[N+i] <= ACC_W'(i_add_term[i]);
            else
               r_acc[i] <= ACC_W'(i_add_term[i]);
         end
      end else if (r_state == S_MAC) begin
         for (int c = 0; c < C; c++) r_acc[c] <= r_acc[c] + w_col_add[c];
         r_b <= r_b >> (LANES * D);
      end
`ifdef MULT_SERIAL_NORM_EN
      if (r_state == S_CARRY) begin
         r_nres   <= w_res;
         r_nidx   <= '0;
         r_ncarry <= '0;
      end else if (r_state == S_NORM) begin
         r_nres   <= w_nres_nxt;
         r_nidx   <= r_nidx + CW'(1);
         r_ncarry <= w_nsum[D:W];
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_dat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept)
            r_row <= '0;
         else if ((r_state == S_MAC) && !w_mac_last)
            r_row <= r_row + RW'(LANES);
`ifdef MULT_SERIAL_NORM_EN
         if ((r_state == S_NORM) && (r_nidx == CW'(C - 1)))
            r_dat <= map_out(w_nres_nxt, r_mode);
`else
         if (r_state == S_CARRY)
            r_dat <= map_out(w_res, r_mode);
`endif
      end
   end

endmodule
